// File: rtl/exe_mem_stage.sv
// EX/MEM pipeline register plus the architectural NZCV status register.
// Feeds carry back to the ALU and evaluates the decode-stage condition field.
module exe_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_sr,
    input  logic        ex_s,
    input  logic        ex_wb_en,
    input  logic        ex_mem_r_en,
    input  logic        ex_mem_w_en,
    input  logic [3:0]  ex_dest,
    input  logic [31:0] ex_st_val,
    input  logic        freeze,
    input  logic        flush,
    input  logic [3:0]  id_cond,
    output logic        mem_valid,
    output logic        mem_wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] mem_alu_res,
    output logic [31:0] mem_st_val,
    output logic [3:0]  mem_dest,
    output logic [3:0]  status,
    output logic        carry_out,
    output logic        cond_pass
);

    logic        valid_q, valid_d;
    logic        wb_en_q, wb_en_d;
    logic        r_en_q, r_en_d;
    logic        w_en_q, w_en_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] st_val_q, st_val_d;
    logic [3:0]  dest_q, dest_d;
    logic [3:0]  status_q, status_d;

    always_comb begin
        valid_d   = valid_q;
        wb_en_d   = wb_en_q;
        r_en_d    = r_en_q;
        w_en_d    = w_en_q;
        alu_res_d = alu_res_q;
        st_val_d  = st_val_q;
        dest_d    = dest_q;
        status_d  = status_q;
        if (!freeze) begin
            if (flush) begin
                valid_d   = 1'b0;
                wb_en_d   = 1'b0;
                r_en_d    = 1'b0;
                w_en_d    = 1'b0;
                alu_res_d = 32'd0;
                st_val_d  = 32'd0;
                dest_d    = 4'd0;
            end else begin
                // Controls are gated so a bubble never writes back or touches memory.
                valid_d   = ex_valid;
                wb_en_d   = ex_valid & ex_wb_en;
                r_en_d    = ex_valid & ex_mem_r_en;
                w_en_d    = ex_valid & ex_mem_w_en;
                alu_res_d = alu_res;
                st_val_d  = ex_st_val;
                dest_d    = ex_dest;
                if (ex_valid && ex_s) begin
                    status_d = {alu_sr[1], alu_sr[3], alu_sr[2], alu_sr[0]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            r_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            alu_res_q <= 32'd0;
            st_val_q  <= 32'd0;
            dest_q    <= 4'd0;
            status_q  <= 4'd0;
        end else begin
            valid_q   <= valid_d;
            wb_en_q   <= wb_en_d;
            r_en_q    <= r_en_d;
            w_en_q    <= w_en_d;
            alu_res_q <= alu_res_d;
            st_val_q  <= st_val_d;
            dest_q    <= dest_d;
            status_q  <= status_d;
        end
    end

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = status_q;

    // Evaluated from the committed register only; no forwarding of in-flight flags.
    always_comb begin
        cond_pass = 1'b0;
        case (id_cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c & !flag_z;
            4'b1001: cond_pass = !flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign mem_valid   = valid_q;
    assign mem_wb_en   = wb_en_q;
    assign mem_r_en    = r_en_q;
    assign mem_w_en    = w_en_q;
    assign mem_alu_res = alu_res_q;
    assign mem_st_val  = st_val_q;
    assign mem_dest    = dest_q;
    assign status      = status_q;
    assign carry_out   = flag_c;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage: a flag-level reference model checked every
// cycle, plus literal expectations for the scenarios that pin that model.
`timescale 1ns/1ps
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_s, ex_wb_en, ex_mem_r_en, ex_mem_w_en;
    logic [31:0] alu_res, ex_st_val;
    logic [3:0]  alu_sr, ex_dest, id_cond;
    logic        freeze, flush;
    logic        mem_valid, mem_wb_en, mem_r_en, mem_w_en;
    logic [31:0] mem_alu_res, mem_st_val;
    logic [3:0]  mem_dest, status;
    logic        carry_out, cond_pass;

    int tests_run = 0;
    int tests_failed = 0;
    bit started = 1'b0;

    exe_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_res(alu_res),
        .alu_sr(alu_sr), .ex_s(ex_s), .ex_wb_en(ex_wb_en),
        .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
        .ex_dest(ex_dest), .ex_st_val(ex_st_val), .freeze(freeze),
        .flush(flush), .id_cond(id_cond), .mem_valid(mem_valid),
        .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_alu_res(mem_alu_res), .mem_st_val(mem_st_val),
        .mem_dest(mem_dest), .status(status), .carry_out(carry_out),
        .cond_pass(cond_pass)
    );

    always #10 clk = ~clk;

    // Reference model: a MEM slot record plus four named flags.
    logic        m_valid = 0, m_wb = 0, m_rd = 0, m_wr = 0;
    logic [31:0] m_res = 0, m_st = 0;
    logic [3:0]  m_dest = 0;
    logic        m_n = 0, m_z = 0, m_c = 0, m_v = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_valid, m_wb, m_rd, m_wr} <= 4'b0;
            m_res <= 0; m_st <= 0; m_dest <= 0;
            {m_n, m_z, m_c, m_v} <= 4'b0;
        end else if (freeze) begin
            m_valid <= m_valid;
        end else if (flush) begin
            {m_valid, m_wb, m_rd, m_wr} <= 4'b0;
            m_res <= 0; m_st <= 0; m_dest <= 0;
        end else begin
            m_valid <= ex_valid;
            m_wb    <= ex_valid ? ex_wb_en : 1'b0;
            m_rd    <= ex_valid ? ex_mem_r_en : 1'b0;
            m_wr    <= ex_valid ? ex_mem_w_en : 1'b0;
            m_res   <= alu_res;
            m_st    <= ex_st_val;
            m_dest  <= ex_dest;
            if (ex_valid && ex_s) begin
                // ALU bus is {Z, C, N, V}
                m_z <= alu_sr[3];
                m_c <= alu_sr[2];
                m_n <= alu_sr[1];
                m_v <= alu_sr[0];
            end
        end
    end

    // Condition: odd codes are the negation of the even code below them.
    function automatic bit ref_cond(input logic [3:0] st, input logic [3:0] c);
        bit n, z, cy, v, r;
        n = st[3]; z = st[2]; cy = st[1]; v = st[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("mem_valid", mem_valid, m_valid);
            check("mem_wb_en", mem_wb_en, m_wb);
            check("mem_r_en", mem_r_en, m_rd);
            check("mem_w_en", mem_w_en, m_wr);
            check("mem_alu_res", mem_alu_res, m_res);
            check("mem_st_val", mem_st_val, m_st);
            check("mem_dest", mem_dest, m_dest);
            check("status", status, {m_n, m_z, m_c, m_v});
            check("carry_out", carry_out, m_c);
            check("cond_pass", cond_pass, ref_cond({m_n, m_z, m_c, m_v}, id_cond));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] sr,
                         input logic [31:0] res, input logic wb, input logic [3:0] dst,
                         input logic fz, input logic fl);
        ex_valid = v; ex_s = s; alu_sr = sr; alu_res = res; ex_wb_en = wb;
        ex_dest = dst; freeze = fz; flush = fl;
        $display("[TB] txn v=%0b s=%0b sr=%b res=%h wb=%0b dest=%0d freeze=%0b flush=%0b",
                 v, s, sr, res, wb, dst, fz, fl);
    endtask

    initial begin
        logic [3:0] n4;
        logic [3:0] c4;
        rst_n = 1'b0;
        ex_valid = 0; ex_s = 0; ex_wb_en = 0; ex_mem_r_en = 0; ex_mem_w_en = 0;
        alu_res = 0; ex_st_val = 0; alu_sr = 0; ex_dest = 0; id_cond = 4'b0001;
        freeze = 0; flush = 0;
        #1 started = 1'b1;
        #14 rst_n = 1'b1;
        #1 check("init_cond_ne", cond_pass, 1);

        // Flag load: Z and C set
        ex_st_val = 32'h0000_00AA; ex_mem_w_en = 1;
        drive(1, 1, 4'b1100, 32'h0000_1234, 1, 4'd5, 0, 0);
        tick();
        check("load_status", status, 4'b0110);
        check("load_carry", carry_out, 1);
        check("load_res", mem_alu_res, 32'h0000_1234);
        check("load_dest", mem_dest, 5);
        check("load_st", mem_st_val, 32'h0000_00AA);
        id_cond = 4'b0000; #1 check("cond_eq", cond_pass, 1);
        id_cond = 4'b1000; #1 check("cond_hi", cond_pass, 0);
        id_cond = 4'b1001; #1 check("cond_ls", cond_pass, 1);
        ex_mem_w_en = 0;

        // No-S and invalid slots leave status alone
        drive(1, 0, 4'b0011, 32'h0000_0001, 1, 4'd2, 0, 0);
        tick();
        check("nos_status", status, 4'b0110);
        check("nos_wb", mem_wb_en, 1);
        drive(0, 1, 4'b0011, 32'h0000_0002, 1, 4'd2, 0, 0);
        tick();
        check("inv_status", status, 4'b0110);
        check("inv_wb", mem_wb_en, 0);
        check("inv_valid", mem_valid, 0);

        // Flush squashes slot and flag update
        drive(1, 1, 4'b0011, 32'hDEADBEEF, 1, 4'd7, 0, 1);
        tick();
        check("flush_res", mem_alu_res, 0);
        check("flush_wb", mem_wb_en, 0);
        check("flush_valid", mem_valid, 0);
        check("flush_status", status, 4'b0110);

        // Freeze dominates flush for 3 cycles
        drive(1, 1, 4'b0010, 32'h1111_1111, 1, 4'd3, 0, 0);
        tick();
        check("pre_freeze_status", status, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4'b1111, 32'hA000_0000 + i, 0, 4'(i + 9), 1, 1);
            tick();
            check("freeze_res", mem_alu_res, 32'h1111_1111);
            check("freeze_dest", mem_dest, 3);
            check("freeze_status", status, 4'b1000);
            check("freeze_valid", mem_valid, 1);
        end
        drive(1, 1, 4'b0001, 32'h2222_2222, 1, 4'd4, 0, 0);
        tick();
        check("release_res", mem_alu_res, 32'h2222_2222);
        check("release_dest", mem_dest, 4);
        check("release_status", status, 4'b0001);

        // Async reset with all inputs nonzero
        ex_mem_r_en = 1; ex_mem_w_en = 1; ex_st_val = 32'hFFFF_FFFF; id_cond = 4'b1111;
        drive(1, 1, 4'b1111, 32'hFFFF_FFFF, 1, 4'hF, 0, 0);
        tick();
        check("prerst_status", status, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", mem_valid, 0);
        check("rst_wb", mem_wb_en, 0);
        check("rst_r", mem_r_en, 0);
        check("rst_w", mem_w_en, 0);
        check("rst_res", mem_alu_res, 0);
        check("rst_st", mem_st_val, 0);
        check("rst_dest", mem_dest, 0);
        check("rst_status", status, 0);
        check("rst_carry", carry_out, 0);
        id_cond = 4'b0001; #1 check("rst_cond_ne", cond_pass, 1);
        id_cond = 4'b0000; #1 check("rst_cond_eq", cond_pass, 0);
        id_cond = 4'b1110; #1 check("rst_cond_al", cond_pass, 1);
        #1 rst_n = 1'b1;
        ex_mem_r_en = 0; ex_mem_w_en = 0; ex_st_val = 0;

        // Condition sweep over all status values
        for (int n = 0; n < 16; n++) begin
            n4 = 4'(n);
            drive(1, 1, {n4[2], n4[1], n4[3], n4[0]}, 32'(n), 0, n4, 0, 0);
            tick();
            ex_valid = 0;
            check("sweep_status", status, 32'(n));
            for (int c = 0; c < 16; c++) begin
                c4 = 4'(c);
                id_cond = c4;
                #1 check("sweep_cond", cond_pass, ref_cond(n4, c4));
            end
            if (n4 == 4'b0000) begin
                id_cond = 4'b1111; #1 check("sweep_nv", cond_pass, 0);
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
